// File: rtl/instr_sequencer.sv
// Drives a multi-cycle CPU through a stored instruction program: load, start,
// wait for completion, capture the result, repeat. A watchdog aborts stalled runs.
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          go,
    input  logic [AW:0]   num_instr,
    output logic [15:0]   cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    input  logic          cpu_w,
    input  logic [15:0]   cpu_out,
    input  logic          cpu_N,
    input  logic          cpu_V,
    input  logic          cpu_Z,
    output logic          busy,
    output logic [15:0]   result,
    output logic [2:0]    flags,
    output logic          result_valid,
    output logic          done,
    output logic          timeout_err
);
    localparam int WDW = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, CAPTURE, FINISH
    } state_t;

    state_t          state, state_next;
    logic [15:0]     mem [DEPTH];
    logic [AW:0]     pc, count, count_go, pc_inc;
    logic [AW-1:0]   addr;
    logic [WDW-1:0]  wdog;
    logic [15:0]     cpu_in_q, result_q;
    logic [2:0]      flags_q;
    logic            waiting, expired, tmo;

    assign count_go = (num_instr > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_instr;
    assign pc_inc   = pc + (AW+1)'(1);
    // pc only addresses memory while pc < count <= DEPTH
    assign addr     = pc[AW-1:0];
    assign waiting  = (state == START) || (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign expired  = waiting && (wdog == WDW'(TIMEOUT));

    always_comb begin
        state_next = state;
        tmo        = 1'b0;
        case (state)
            IDLE:      if (go) state_next = (count_go == '0) ? FINISH : LOAD;
            LOAD:      state_next = START;
            START: begin
                if (cpu_w)        state_next = WAIT_BUSY;
                else if (expired) tmo = 1'b1;
            end
            WAIT_BUSY: begin
                if (!cpu_w)       state_next = WAIT_DONE;
                else if (expired) tmo = 1'b1;
            end
            WAIT_DONE: begin
                if (cpu_w)        state_next = CAPTURE;
                else if (expired) tmo = 1'b1;
            end
            CAPTURE:   state_next = (pc_inc == count) ? FINISH : LOAD;
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (tmo) state_next = IDLE;
    end

    // Outputs are visible in the same cycle as their state; the registers hold them afterwards
    always_comb begin
        busy         = (state != IDLE);
        cpu_load     = (state == LOAD);
        cpu_s        = (state == START) && cpu_w;
        result_valid = (state == CAPTURE);
        done         = (state == FINISH) || tmo;
        cpu_in       = (state == LOAD)    ? mem[addr] : cpu_in_q;
        result       = (state == CAPTURE) ? cpu_out   : result_q;
        flags        = (state == CAPTURE) ? {cpu_N, cpu_V, cpu_Z} : flags_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= '0;
            count       <= '0;
            wdog        <= '0;
            cpu_in_q    <= '0;
            result_q    <= '0;
            flags_q     <= 3'b000;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && go) begin
                pc          <= '0;
                count       <= count_go;
                timeout_err <= 1'b0;
            end
            if (tmo) timeout_err <= 1'b1;
            if (state == LOAD) cpu_in_q <= mem[addr];
            if (state == CAPTURE) begin
                result_q <= cpu_out;
                flags_q  <= {cpu_N, cpu_V, cpu_Z};
                pc       <= pc_inc;
            end
            if (state_next != state) wdog <= '0;
            else if (waiting)        wdog <= wdog + WDW'(1);
        end
    end

    // Program memory survives reset
    always_ff @(posedge clk) begin
        if (reset && state == IDLE && wr_en) mem[wr_addr] <= wr_data;
    end

endmodule
